// File: rtl/piso_pkg.sv
// Shared types and sizing for the PISO scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package piso_pkg;

  // Width of one 74HC165-style parallel-in/serial-out device.
  localparam int PISO_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOW,
    HIGH,
    DONE
  } state_e;

  // Bits captured per scan for a chain of chain_len devices.
  function automatic int scan_bits(input int chain_len);
    return PISO_W * chain_len;
  endfunction

endpackage

// File: rtl/piso_phase_timer.sv
// Phase timer: counts CLK_DIV cycles per controller phase and flags the last one.
// Latency: last is combinational from the count register; a clear restarts at 0 next cycle.
// Backpressure: none; en low or clr high holds the count at 0.
//
// Ports: clk/rst_n (sync, active-low), en (timed phase active),
//        clr (phase changes this cycle), last (final cycle of the phase).
module piso_phase_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic last
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign last = en && (cnt_q == 8'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (!last) begin
      // Saturate on the last cycle; the phase change clears it anyway.
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_scan_ctrl.sv
// PISO scan controller: loads a cascaded 8-bit PISO chain, clocks it out and deserialises QH.
// Latency: START accepted at edge k -> VALID in cycle k+1+2*N*CLK_DIV.
// Backpressure: none; START is ignored while busy, CONT chains scans back to back.
//
// Ports: CLK/RST_N (sync, active-low); START, CONT requests; QH serial input;
//        SH_LD, CLK_INH, SR_CLK drive the chain; DOUT/VALID captured word; BUSY scan active.
module piso_scan_ctrl
  import piso_pkg::*;
#(
  parameter int CHAIN_LEN = 1,
  parameter int CLK_DIV   = 2
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          START,
  input  logic                          CONT,
  input  logic                          QH,
  output logic                          SH_LD,
  output logic                          CLK_INH,
  output logic                          SR_CLK,
  output logic [PISO_W*CHAIN_LEN-1:0]   DOUT,
  output logic                          VALID,
  output logic                          BUSY
);

  localparam int N  = scan_bits(CHAIN_LEN);
  localparam int BW = $clog2(N + 1);

  state_e          state_q, state_d;
  logic [N-1:0]    sr_q, sr_d;
  logic [N-1:0]    dout_q, dout_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            sh_ld_q, sh_ld_d;
  logic            clk_inh_q, clk_inh_d;
  logic            sr_clk_q, sr_clk_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;

  logic            timer_en;
  logic            phase_clr;
  logic            phase_last;

  assign timer_en  = (state_q == LOAD) || (state_q == LOW) || (state_q == HIGH);
  assign phase_clr = (state_d != state_q);

  piso_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (timer_en),
    .clr   (phase_clr),
    .last  (phase_last)
  );

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    dout_d    = dout_q;

    case (state_q)
      IDLE: begin
        if (START) state_d = LOAD;
      end
      LOAD: begin
        bit_cnt_d = '0;
        if (phase_last) state_d = LOW;
      end
      LOW: begin
        // Sample at the end of the low phase so QH has had CLK_DIV cycles to settle.
        if (phase_last) begin
          sr_d      = {sr_q[N-2:0], QH};
          bit_cnt_d = bit_cnt_q + BW'(1);
          state_d   = (bit_cnt_q == BW'(N - 1)) ? DONE : HIGH;
        end
      end
      HIGH: begin
        if (phase_last) state_d = LOW;
      end
      DONE: begin
        state_d = CONT ? LOAD : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state, so each pin matches the state it is in
    // without a decode stage after the flops.
    sh_ld_d   = (state_d != LOAD);
    clk_inh_d = !((state_d == LOW) || (state_d == HIGH));
    sr_clk_d  = (state_d == HIGH);
    busy_d    = (state_d != IDLE);
    valid_d   = (state_d == DONE);
    if (state_d == DONE) dout_d = sr_d;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      dout_q    <= '0;
      bit_cnt_q <= '0;
      sh_ld_q   <= 1'b1;
      clk_inh_q <= 1'b1;
      sr_clk_q  <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      dout_q    <= dout_d;
      bit_cnt_q <= bit_cnt_d;
      sh_ld_q   <= sh_ld_d;
      clk_inh_q <= clk_inh_d;
      sr_clk_q  <= sr_clk_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign SH_LD   = sh_ld_q;
  assign CLK_INH = clk_inh_q;
  assign SR_CLK  = sr_clk_q;
  assign DOUT    = dout_q;
  assign VALID   = valid_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_piso_scan_ctrl.sv
// Bench for piso_scan_ctrl: two instances (1 device / CLK_DIV=2 and 2 devices / CLK_DIV=1),
// each driving a PISO chain model, checked every cycle against a timeline model.
// Directed scenarios add literal expectations on latency, data, edge counts and reset.
module tb_piso_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic        rst_n   [2];
  logic        start   [2];
  logic        cont    [2];
  logic        qh      [2];
  logic [15:0] par     [2];
  logic        sh_ld   [2];
  logic        clk_inh [2];
  logic        sr_clk  [2];
  logic        valid   [2];
  logic        busy    [2];
  logic [7:0]  dout0;
  logic [15:0] dout1;

  piso_scan_ctrl #(.CHAIN_LEN(1), .CLK_DIV(2)) u0 (
    .CLK(clk), .RST_N(rst_n[0]), .START(start[0]), .CONT(cont[0]), .QH(qh[0]),
    .SH_LD(sh_ld[0]), .CLK_INH(clk_inh[0]), .SR_CLK(sr_clk[0]),
    .DOUT(dout0), .VALID(valid[0]), .BUSY(busy[0])
  );

  piso_scan_ctrl #(.CHAIN_LEN(2), .CLK_DIV(1)) u1 (
    .CLK(clk), .RST_N(rst_n[1]), .START(start[1]), .CONT(cont[1]), .QH(qh[1]),
    .SH_LD(sh_ld[1]), .CLK_INH(clk_inh[1]), .SR_CLK(sr_clk[1]),
    .DOUT(dout1), .VALID(valid[1]), .BUSY(busy[1])
  );

  function automatic int nb(input int g);
    return (g == 0) ? 8 : 16;
  endfunction

  function automatic int dv(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  function automatic logic [15:0] mask(input int g);
    return (g == 0) ? 16'h00FF : 16'hFFFF;
  endfunction

  function automatic logic [15:0] dout_of(input int g);
    return (g == 0) ? {8'h00, dout0} : dout1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // PISO chain model: level load while SH_LD=0, shift on SR_CLK rise when not inhibited.
  // The first bit out is the MSB of the loaded word.
  logic [15:0] chain   [2];
  logic        sr_prev [2];
  assign qh[0] = chain[0][7];
  assign qh[1] = chain[1][15];

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      sr_prev[g] <= sr_clk[g];
      if (!sh_ld[g]) chain[g] <= par[g] & mask(g);
      else if (!clk_inh[g] && sr_clk[g] && !sr_prev[g]) chain[g] <= chain[g] << 1;
    end
  end

  // Timeline model: m_t is the cycle offset within a scan; the scan lasts 2*N*D cycles
  // (phase p = t/D: 0 load, odd low, even high) followed by one DONE cycle.
  bit          m_ok   [2] = '{0, 0};
  bit          m_scan [2] = '{0, 0};
  int          m_t    [2] = '{0, 0};
  logic [15:0] m_word [2] = '{16'h0, 16'h0};
  logic [15:0] m_dout [2] = '{16'h0, 16'h0};

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n[g]) begin
        m_ok[g]   <= 1'b1;
        m_scan[g] <= 1'b0;
        m_t[g]    <= 0;
        m_dout[g] <= '0;
      end else if (!m_scan[g]) begin
        if (start[g]) begin
          m_scan[g] <= 1'b1;
          m_t[g]    <= 0;
        end
      end else begin
        if (m_t[g] < dv(g)) m_word[g] <= par[g] & mask(g);
        if (m_t[g] == 2 * nb(g) * dv(g)) begin
          m_dout[g] <= m_word[g];
          m_scan[g] <= cont[g];
          m_t[g]    <= 0;
        end else begin
          m_t[g] <= m_t[g] + 1;
        end
      end
    end
  end

  // Expected {SH_LD, CLK_INH, SR_CLK, VALID, BUSY} for the current cycle.
  function automatic logic [4:0] exp_ctl(input int g);
    int p;
    if (!m_scan[g]) return 5'b11000;
    if (m_t[g] == 2 * nb(g) * dv(g)) return 5'b11011;
    p = m_t[g] / dv(g);
    if (p == 0) return 5'b01001;
    if (p % 2 == 1) return 5'b10001;
    return 5'b10101;
  endfunction

  function automatic logic [15:0] exp_dout(input int g);
    if (m_scan[g] && m_t[g] == 2 * nb(g) * dv(g)) return m_word[g];
    return m_dout[g];
  endfunction

  // Per-cycle compare, protocol checks and event counters.
  bit   have_prev [2] = '{0, 0};
  logic p_sh [2], p_inh [2], p_sr [2];
  int   valid_cnt [2] = '{0, 0};
  int   valid_cyc [2] = '{0, 0};
  int   rise_cnt  [2] = '{0, 0};
  int   ld_fall   [2] = '{0, 0};
  int   ld_low    [2] = '{0, 0};
  logic [15:0] last_dout [2] = '{16'h0, 16'h0};

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (m_ok[g]) begin
        chk($sformatf("u%0d ctl{SH_LD,CLK_INH,SR_CLK,VALID,BUSY}", g),
            {sh_ld[g], clk_inh[g], sr_clk[g], valid[g], busy[g]}, exp_ctl(g));
        chk($sformatf("u%0d DOUT", g), dout_of(g), exp_dout(g));
        if (have_prev[g]) begin
          chk($sformatf("u%0d SH_LD and SR_CLK toggle together", g),
              (sh_ld[g] !== p_sh[g]) && (sr_clk[g] !== p_sr[g]), 0);
          chk($sformatf("u%0d CLK_INH rise while SR_CLK high", g),
              clk_inh[g] && !p_inh[g] && p_sr[g], 0);
          if (sr_clk[g] && !p_sr[g]) rise_cnt[g] <= rise_cnt[g] + 1;
          if (!sh_ld[g] && p_sh[g]) ld_fall[g] <= ld_fall[g] + 1;
        end
        if (!sh_ld[g]) ld_low[g] <= ld_low[g] + 1;
        if (valid[g]) begin
          valid_cnt[g] <= valid_cnt[g] + 1;
          valid_cyc[g] <= cyc;
          last_dout[g] <= dout_of(g);
        end
        have_prev[g] <= 1'b1;
        p_sh[g]  <= sh_ld[g];
        p_inh[g] <= clk_inh[g];
        p_sr[g]  <= sr_clk[g];
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int g, output int s);
    start[g] = 1'b1;
    s = cyc;
    step(1);
    start[g] = 1'b0;
  endtask

  task automatic wait_valid(input int g, input int budget, input string name);
    int  v0;
    bit  seen;
    v0   = valid_cnt[g];
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1);
      if (valid_cnt[g] != v0) seen = 1'b1;
    end
    chk(name, seen, 1);
  endtask

  initial begin
    int s, v, r, f, l;
    int c1, c2, c3;
    logic [15:0] d1, d2, d3;

    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0; start[g] = 1'b0; cont[g] = 1'b0; par[g] = 16'h0;
    end
    step(3);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("u%0d reset ctl", g),
          {sh_ld[g], clk_inh[g], sr_clk[g], valid[g], busy[g]}, 5'b11000);
      chk($sformatf("u%0d reset DOUT", g), dout_of(g), 0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    step(5);

    // Single scan, one device, CLK_DIV=2.
    par[0] = 16'h00B2;
    v = valid_cnt[0]; r = rise_cnt[0]; l = ld_low[0];
    pulse_start(0, s);
    step(40);
    chk("t1 valid count", valid_cnt[0] - v, 1);
    chk("t1 latency", valid_cyc[0] - s, 33);
    chk("t1 DOUT", last_dout[0], 16'h00B2);
    chk("t1 SR_CLK rises", rise_cnt[0] - r, 7);
    chk("t1 SH_LD low cycles", ld_low[0] - l, 2);
    chk("t1 BUSY after", busy[0], 0);

    // Two devices, CLK_DIV=1.
    par[1] = 16'hA53C;
    v = valid_cnt[1]; r = rise_cnt[1];
    pulse_start(1, s);
    step(40);
    chk("t2 valid count", valid_cnt[1] - v, 1);
    chk("t2 latency", valid_cyc[1] - s, 33);
    chk("t2 DOUT", last_dout[1], 16'hA53C);
    chk("t2 SR_CLK rises", rise_cnt[1] - r, 15);

    // Continuous mode with a changing pattern, CONT dropped during the third scan.
    par[0] = 16'h0000; cont[0] = 1'b1;
    v = valid_cnt[0];
    pulse_start(0, s);
    wait_valid(0, 40, "t3 scan1 valid");
    d1 = last_dout[0]; c1 = valid_cyc[0]; par[0] = 16'h00FF;
    wait_valid(0, 40, "t3 scan2 valid");
    d2 = last_dout[0]; c2 = valid_cyc[0]; par[0] = 16'h005A; cont[0] = 1'b0;
    wait_valid(0, 40, "t3 scan3 valid");
    d3 = last_dout[0]; c3 = valid_cyc[0];
    step(5);
    chk("t3 DOUT scan1", d1, 16'h0000);
    chk("t3 DOUT scan2", d2, 16'h00FF);
    chk("t3 DOUT scan3", d3, 16'h005A);
    chk("t3 interval 1-2", c2 - c1, 33);
    chk("t3 interval 2-3", c3 - c2, 33);
    chk("t3 valid count", valid_cnt[0] - v, 3);
    chk("t3 back to idle", busy[0], 0);

    // START re-asserted while busy is ignored.
    par[0] = 16'h00C3;
    v = valid_cnt[0]; f = ld_fall[0];
    pulse_start(0, s);
    step(5);
    start[0] = 1'b1;
    step(3);
    start[0] = 1'b0;
    step(40);
    chk("t4 valid count", valid_cnt[0] - v, 1);
    chk("t4 SH_LD loads", ld_fall[0] - f, 1);
    chk("t4 DOUT", last_dout[0], 16'h00C3);

    // Reset during the low phase of bit 4, then a fresh scan.
    par[0] = 16'h00FF;
    v = valid_cnt[0];
    pulse_start(0, s);
    step(14);
    rst_n[0] = 1'b0;
    step(1);
    rst_n[0] = 1'b1;
    chk("t5 ctl after reset", {sh_ld[0], clk_inh[0], sr_clk[0], valid[0], busy[0]}, 5'b11000);
    chk("t5 DOUT after reset", dout_of(0), 0);
    step(40);
    chk("t5 no valid after reset", valid_cnt[0] - v, 0);
    par[0] = 16'h0096;
    pulse_start(0, s);
    step(40);
    chk("t5 fresh valid count", valid_cnt[0] - v, 1);
    chk("t5 fresh latency", valid_cyc[0] - s, 33);
    chk("t5 fresh DOUT", last_dout[0], 16'h0096);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
